prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader and run supervisor for the 16-bit RISC SoC. It accepts a byte stream containing a program image, writes each 16-bit instruction word into instruction memory, and holds the core in reset until the image is complete. It then releases the core, counts executed clock cycles until the core asserts `holt`, and reports completion. It is the writing and controlling end of the instruction-fetch path: the IFU reads what this block writes.

## Interface
- `ADDR_W`, 8: instruction memory address width; capacity is 2^ADDR_W words.
- `CNT_W`, 16: cycle counter width.

- `CLK`  in  1  clock.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  loader can accept a byte.
- `imem_we`  out  1  instruction memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  16  write data.
- `core_rst_n`  out  1  core reset; active-low.
- `holt`  in  1  core halt indication.
- `cycle_count`  out  CNT_W  core cycles executed.
- `done`  out  1  core has halted.
- `ovf`  out  1  sticky flag: image exceeded capacity.
- `err`  out  1  checksum failure; see Configuration.

## Operation
- Stream format, high byte first throughout: 2-byte word count N, then N words of 2 bytes each, then an optional checksum byte.
- A byte transfers at a posedge where `in_valid && in_ready`.
- States:
  - `HDR_HI`: reset state.
  - `HDR_LO`
  - `DAT_HI`
  - `DAT_LO`
  - `CHK`: present only when the checksum is enabled.
  - `RUN`
  - `HALTED`
  - `ERROR`
- Transitions:
  - `HDR_HI` → `HDR_LO` → `DAT_HI` when N>0.
  - When N=0, `HDR_LO` goes directly to `CHK`/`RUN`.
  - `DAT_HI` → `DAT_LO`.
  - `DAT_LO` → `DAT_HI` while words remain, otherwise → `CHK`/`RUN`.
- Word index `idx` counts 0..N-1 and is 16 bits wide.
- Address: `imem_addr` = `idx[ADDR_W-1:0]`.
  - A word with `idx >= 2^ADDR_W` is not written (`imem_we` stays 0) and sets `ovf`.
  - Loading continues and the stream is still consumed.
- `in_ready` is 1 in `HDR_HI`, `HDR_LO`, `DAT_HI`, `DAT_LO` and `CHK`; it is 0 otherwise.
- In `RUN`, `cycle_count` increments once per cycle while `core_rst_n`=1 and `holt`=0. It saturates at all-ones.
- `holt`=1 sampled in `RUN` → `HALTED`. `cycle_count` freezes and `done`=1.
- `HALTED` and `ERROR` are terminal; only `RST_N` exits them.
- `holt` is ignored outside `RUN`.

## Timing
- Reset values:
  - `in_ready`=1
  - `imem_we`=0
  - `imem_addr`=0
  - `imem_wdata`=0
  - `core_rst_n`=0
  - `cycle_count`=0
  - `done`=0
  - `ovf`=0
  - `err`=0
  - state `HDR_HI`
- All outputs are registered.
- Low byte of a word accepted at edge k:
  - `imem_we`=1 with the address and data during cycle k..k+1.
  - Back-to-back words produce one strobe per word.
- Final byte accepted at edge k (last data byte, checksum byte, or header low byte when N=0):
  - State becomes `RUN` at edge k.
  - `core_rst_n` rises at edge k+1, after the last write has completed.
- First possible `cycle_count` increment is at edge k+2.
- `holt` high at edge h: `done`=1 and the count is frozen from edge h. The value counts every cycle up to but excluding h.
- Stalls: `in_valid` low for any number of cycles holds state; no timeout.
- Asynchronous `RST_N` mid-load or mid-run:
  - All outputs return to reset values immediately and the partial image is discarded.
  - Memory contents already written are not cleared.
  - The core re-enters reset.

## Configuration
- Macro `PROG_LOADER_CHECKSUM_EN`.
- Defined:
  - State `CHK` expects one byte after the data.
  - The running XOR covers all header and data bytes.
  - On match → `RUN`.
  - On mismatch → `ERROR`: `err`=1, `in_ready`=0, `core_rst_n` remains 0.
- Undefined:
  - No checksum byte.
  - `CHK` and `ERROR` are absent.
  - `err` is tied to 0.

## Test plan
- Checksum off: stream 00 03 12 34 AB CD 00 01.
  - Required writes: (0,1234), (1,ABCD), (2,0001), with `imem_we` high exactly 3 cycles.
  - `core_rst_n` rises 1 cycle after the last strobe.
- N=0: stream 00 00.
  - No writes; `core_rst_n` rises 1 cycle after the second byte.
  - With `holt` tied high, `done`=1 and `cycle_count`=0.
- Run: load 1 word, hold `holt`=0 for 25 core cycles, then raise it.
  - `cycle_count`=25, `done`=1.
  - The count is unchanged 10 cycles later.
- Overflow with `ADDR_W`=2: N=5.
  - Addresses 0..3 are written; word 5 gives no strobe.
  - `ovf`=1 and the load completes.
- Checksum on: stream 00 01 12 34 followed by checksum 27 → `RUN`.
  - The same stream with checksum 26 → `err`=1, `core_rst_n`=0, `in_ready`=0.
- Reset mid-load after 3 bytes.
  - Outputs return to reset values; a full reload then behaves exactly as the first scenario.
- Random `in_valid` gaps give results identical to the ungapped runs.

Source files
------------

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader and run supervisor for the 16-bit RISC SoC.
// A byte stream carrying a program image is written word by word into
// instruction memory while the core is held in reset. Once the image is
// complete the core is released, and its executed cycles are counted until
// it raises holt.
//
// Stream format, high byte first throughout:
//   word count N (2 bytes), N words (2 bytes each), optional checksum byte.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
//   defined   : one checksum byte follows the data. It must equal the XOR of
//               all header and data bytes. A mismatch parks the loader in
//               ERROR with err=1 and the core kept in reset.
//   undefined : no checksum byte is expected and err is tied to 0.
//
// Parameters
//   ADDR_W      instruction memory address width (capacity 2^ADDR_W words)
//   CNT_W       cycle counter width
//
// Ports
//   CLK         clock
//   RST_N       asynchronous active-low reset
//   in_valid    byte-stream valid
//   in_data     byte-stream data
//   in_ready    loader can accept a byte
//   imem_we     instruction memory write strobe, one cycle per word
//   imem_addr   instruction memory write address
//   imem_wdata  instruction memory write data
//   core_rst_n  core reset, active-low
//   holt        core halt indication (only looked at while running)
//   cycle_count core cycles executed, saturating
//   done        core has halted
//   ovf         sticky: image was larger than instruction memory
//   err         checksum failure
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              core_rst_n,
    input  logic              holt,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              done,
    output logic              ovf,
    output logic              err
);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DAT_HI,
        DAT_LO,
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK,
        ERROR,
`endif
        RUN,
        HALTED
    } loaderState_e;

    // Number of words instruction memory can hold; one extra bit so that
    // ADDR_W=16 still yields a representable bound.
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

    loaderState_e      state_q, state_d;
    logic [15:0]       wordCount_q, wordCount_d;
    logic [15:0]       idx_q, idx_d;
    logic [7:0]        hiByte_q, hiByte_d;
    logic              inReady_q, inReady_d;
    logic              imemWe_q, imemWe_d;
    logic [ADDR_W-1:0] imemAddr_q, imemAddr_d;
    logic [15:0]       imemWdata_q, imemWdata_d;
    logic              coreRstN_q, coreRstN_d;
    logic [CNT_W-1:0]  cycleCount_q, cycleCount_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
    logic              err_q, err_d;
`endif

    logic              accept;
    logic              lastByte;
    logic              wordFits;

    // State and output registers. Every output comes straight from a flop,
    // and an asynchronous reset drops the core back into reset at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= HDR_HI;
            wordCount_q  <= '0;
            idx_q        <= '0;
            hiByte_q     <= '0;
            inReady_q    <= 1'b1;
            imemWe_q     <= 1'b0;
            imemAddr_q   <= '0;
            imemWdata_q  <= '0;
            coreRstN_q   <= 1'b0;
            cycleCount_q <= '0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wordCount_q  <= wordCount_d;
            idx_q        <= idx_d;
            hiByte_q     <= hiByte_d;
            inReady_q    <= inReady_d;
            imemWe_q     <= imemWe_d;
            imemAddr_q   <= imemAddr_d;
            imemWdata_q  <= imemWdata_d;
            coreRstN_q   <= coreRstN_d;
            cycleCount_q <= cycleCount_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q        <= chk_d;
            err_q        <= err_d;
`endif
        end
    end

    // Next-state and next-output logic. in_ready is registered, so the
    // handshake uses the registered copy and the next value is derived from
    // the state being entered.
    always_comb begin
        state_d      = state_q;
        wordCount_d  = wordCount_q;
        idx_d        = idx_q;
        hiByte_d     = hiByte_q;
        imemWe_d     = 1'b0;
        imemAddr_d   = imemAddr_q;
        imemWdata_d  = imemWdata_q;
        coreRstN_d   = coreRstN_q;
        cycleCount_d = cycleCount_q;
        done_d       = done_q;
        ovf_d        = ovf_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_d        = chk_q;
        err_d        = err_q;
`endif
        accept   = in_valid && inReady_q;
        lastByte = 1'b0;
        wordFits = ({1'b0, idx_q} < CAPACITY);

        case (state_q)
            HDR_HI: begin
                if (accept) begin
                    wordCount_d = {in_data, 8'h00};
                    state_d     = HDR_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d       = chk_q ^ in_data;
`endif
                end
            end

            HDR_LO: begin
                if (accept) begin
                    wordCount_d = {wordCount_q[15:8], in_data};
                    idx_d       = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d       = chk_q ^ in_data;
`endif
                    // An empty image finishes on its header.
                    if ({wordCount_q[15:8], in_data} == 16'd0) begin
                        lastByte = 1'b1;
                    end else begin
                        state_d = DAT_HI;
                    end
                end
            end

            DAT_HI: begin
                if (accept) begin
                    hiByte_d = in_data;
                    state_d  = DAT_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d    = chk_q ^ in_data;
`endif
                end
            end

            DAT_LO: begin
                if (accept) begin
                    // Words beyond the memory are consumed but never written;
                    // they only leave the sticky overflow flag behind.
                    if (wordFits) begin
                        imemWe_d    = 1'b1;
                        imemAddr_d  = idx_q[ADDR_W-1:0];
                        imemWdata_d = {hiByte_q, in_data};
                    end else begin
                        ovf_d = 1'b1;
                    end
                    idx_d = idx_q + 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ in_data;
`endif
                    if (idx_q == wordCount_q - 16'd1) begin
                        lastByte = 1'b1;
                    end else begin
                        state_d = DAT_HI;
                    end
                end
            end

`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    if (in_data == chk_q) begin
                        state_d = RUN;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
            end

            ERROR: begin
            end
`endif

            RUN: begin
                // Release happens one cycle after entering RUN so the final
                // memory write has completed before the core fetches. The
                // first countable cycle is the one after the release edge.
                coreRstN_d = 1'b1;
                if (holt) begin
                    state_d = HALTED;
                    done_d  = 1'b1;
                end else if (coreRstN_q && (cycleCount_q != {CNT_W{1'b1}})) begin
                    cycleCount_d = cycleCount_q + CNT_W'(1);
                end
            end

            HALTED: begin
            end

            default: begin
                state_d = HDR_HI;
            end
        endcase

        if (lastByte) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = RUN;
`endif
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        inReady_d = (state_d == HDR_HI) || (state_d == HDR_LO) ||
                    (state_d == DAT_HI) || (state_d == DAT_LO) ||
                    (state_d == CHK);
`else
        inReady_d = (state_d == HDR_HI) || (state_d == HDR_LO) ||
                    (state_d == DAT_HI) || (state_d == DAT_LO);
`endif
    end

    assign in_ready    = inReady_q;
    assign imem_we     = imemWe_q;
    assign imem_addr   = imemAddr_q;
    assign imem_wdata  = imemWdata_q;
    assign core_rst_n  = coreRstN_q;
    assign cycle_count = cycleCount_q;
    assign done        = done_q;
    assign ovf         = ovf_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign err         = err_q;
`else
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Self-checking bench for prog_loader. The loader is built with a 4-word
// instruction memory and a 5-bit cycle counter so that overflow and counter
// saturation are reachable with short streams. Expected memory writes are
// queued while a stream is built and are retired by a write monitor as the
// loader strobes instruction memory. Scenario tasks check everything else.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prog_loader;

    localparam int ADDR_W = 2;
    localparam int CNT_W  = 5;

    logic              CLK      = 1'b0;
    logic              RST_N    = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data  = 8'h00;
    logic              holt     = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              core_rst_n;
    logic [CNT_W-1:0]  cycle_count;
    logic              done;
    logic              ovf;
    logic              err;

    prog_loader #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .core_rst_n  (core_rst_n),
        .holt        (holt),
        .cycle_count (cycle_count),
        .done        (done),
        .ovf         (ovf),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;

    // Cycle number of the most recent rising clock edge.
    always @(posedge CLK) cyc <= cyc + 1;

    logic [ADDR_W+15:0] expQ[$];
    logic [15:0]        imgWords[$];
    logic [ADDR_W+15:0] expWord;
    int                 weCount       = 0;
    int                 lastStrobeCyc = -1;
    int                 riseCyc       = -1;
    int                 lastAcceptCyc = -1;
    logic               prevRstN      = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]         chkFlip       = 8'h00;
`endif

    // Write monitor: every strobe retires the oldest expected write. It also
    // notes the cycle in which the core is first seen out of reset.
    always @(negedge CLK) begin
        if (imem_we === 1'b1) begin
            weCount       = weCount + 1;
            lastStrobeCyc = cyc;
            testsRun      = testsRun + 1;
            if (expQ.size() == 0) begin
                testsFailed = testsFailed + 1;
                $display("[TB] FAIL imem_write: got addr=%0d data=%h, required no write",
                         imem_addr, imem_wdata);
            end else begin
                expWord = expQ.pop_front();
                if ({imem_addr, imem_wdata} !== expWord) begin
                    testsFailed = testsFailed + 1;
                    $display("[TB] FAIL imem_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             imem_addr, imem_wdata, expWord[ADDR_W+15:16], expWord[15:0]);
                end
            end
        end
        if (core_rst_n === 1'b1 && prevRstN !== 1'b1) riseCyc = cyc;
        prevRstN = core_rst_n;
    end

    // Hard stop in case something upstream never returns.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Forget any bookkeeping from the previous scenario.
    task automatic clearTracking();
        expQ.delete();
        weCount       = 0;
        lastStrobeCyc = -1;
        riseCyc       = -1;
        lastAcceptCyc = -1;
    endtask

    // Synchronous-looking reset pulse; entered and left just after an edge.
    task automatic pulseReset();
        in_valid = 1'b0;
        RST_N    = 1'b0;
        #2;
        clearTracking();
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // Offer one byte after an optional idle gap and wait until it transfers.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int   budget;
        logic rdy;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge CLK);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        budget   = 0;
        forever begin
            rdy = in_ready;
            @(posedge CLK);
            #1;
            if (rdy === 1'b1) break;
            budget = budget + 1;
            if (budget > 20) begin
                testsRun    = testsRun + 1;
                testsFailed = testsFailed + 1;
                $display("[TB] FAIL byte_accept: byte %h not taken, in_ready=%b, required 1", b, in_ready);
                break;
            end
        end
        lastAcceptCyc = cyc;
    endtask

    // Build the stream for imgWords with header n, queue the writes that
    // must reach memory, and drive it with random gaps up to gapMax.
    task automatic loadImage(input int n, input int gapMax);
        logic [7:0]        streamBytes[$];
        logic [ADDR_W-1:0] a;
        logic [15:0]       hdr;
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0]        chk;
`endif
        hdr = n[15:0];
        streamBytes.push_back(hdr[15:8]);
        streamBytes.push_back(hdr[7:0]);
        for (int i = 0; i < imgWords.size(); i++) begin
            streamBytes.push_back(imgWords[i][15:8]);
            streamBytes.push_back(imgWords[i][7:0]);
            if (i < (1 << ADDR_W)) begin
                a = i[ADDR_W-1:0];
                expQ.push_back({a, imgWords[i]});
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        chk = 8'h00;
        for (int i = 0; i < streamBytes.size(); i++) chk = chk ^ streamBytes[i];
        streamBytes.push_back(chk ^ chkFlip);
`endif
        for (int i = 0; i < streamBytes.size(); i++) begin
            applyStimulus(streamBytes[i], (gapMax > 0) ? $urandom_range(0, gapMax) : 0);
        end
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for the core to leave reset.
    task automatic waitCoreRelease();
        int budget;
        budget = 0;
        while (core_rst_n !== 1'b1 && budget < 10) begin
            @(posedge CLK);
            #1;
            budget = budget + 1;
        end
        testsRun = testsRun + 1;
        if (core_rst_n !== 1'b1) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL core_release: core_rst_n=%b, required 1", core_rst_n);
        end
    endtask

    task automatic test_reset();
        #1;
        RST_N = 1'b0;
        #1;
        testsRun = testsRun + 1;
        if ({in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, cycle_count, done, ovf, err}
            !== {1'b1, 1'b0, {ADDR_W{1'b0}}, 16'h0000, 1'b0, {CNT_W{1'b0}}, 3'b000}) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL reset_values: got rdy=%b we=%b addr=%0d wdata=%h crst=%b cnt=%0d done=%b ovf=%b err=%b, required rdy=1 rest 0",
                     in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, cycle_count, done, ovf, err);
        end
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        testsRun = testsRun + 1;
        if ({in_ready, imem_we, core_rst_n, done} !== 4'b1000) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL idle_after_reset: got rdy=%b we=%b crst=%b done=%b, required 1 0 0 0",
                     in_ready, imem_we, core_rst_n, done);
        end
    endtask

    task automatic test_basic_load(input int gapMax, input bit withReset);
        if (withReset) pulseReset();
        holt = 1'b0;
        imgWords.delete();
        imgWords.push_back(16'h1234);
        imgWords.push_back(16'hABCD);
        imgWords.push_back(16'h0001);
        loadImage(3, gapMax);
        repeat (3) @(posedge CLK);
        #1;
        testsRun = testsRun + 1;
        if (weCount !== 3) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL basic_write_count: got %0d strobes, required 3", weCount);
        end
        testsRun = testsRun + 1;
        if (expQ.size() !== 0) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL basic_pending: got %0d writes missing, required 0", expQ.size());
        end
        testsRun = testsRun + 1;
        if (riseCyc !== lastAcceptCyc + 1) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL basic_release_time: got cycle %0d, required %0d", riseCyc, lastAcceptCyc + 1);
        end
`ifndef PROG_LOADER_CHECKSUM_EN
        testsRun = testsRun + 1;
        if (riseCyc !== lastStrobeCyc + 1) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL basic_release_after_strobe: got cycle %0d, required %0d", riseCyc, lastStrobeCyc + 1);
        end
`endif
        testsRun = testsRun + 1;
        if ({in_ready, done, ovf, err} !== 4'b0000) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL basic_flags: got rdy=%b done=%b ovf=%b err=%b, required 0 0 0 0",
                     in_ready, done, ovf, err);
        end
    endtask

    task automatic test_empty_image();
        pulseReset();
        holt = 1'b1;
        imgWords.delete();
        loadImage(0, 0);
        repeat (3) @(posedge CLK);
        #1;
        testsRun = testsRun + 1;
        if (weCount !== 0) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL empty_writes: got %0d strobes, required 0", weCount);
        end
        testsRun = testsRun + 1;
        if (riseCyc !== lastAcceptCyc + 1) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL empty_release_time: got cycle %0d, required %0d", riseCyc, lastAcceptCyc + 1);
        end
        testsRun = testsRun + 1;
        if ({done, cycle_count} !== {1'b1, {CNT_W{1'b0}}}) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL empty_halt: got done=%b cnt=%0d, required done=1 cnt=0", done, cycle_count);
        end
        holt = 1'b0;
    endtask

    task automatic test_run_count();
        pulseReset();
        holt = 1'b0;
        imgWords.delete();
        imgWords.push_back(16'h5A5A);
        loadImage(1, 0);
        waitCoreRelease();
        repeat (25) @(posedge CLK);
        #1;
        testsRun = testsRun + 1;
        if ({done, cycle_count} !== {1'b0, 5'd25}) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL run_before_halt: got done=%b cnt=%0d, required done=0 cnt=25", done, cycle_count);
        end
        holt = 1'b1;
        @(posedge CLK);
        #1;
        testsRun = testsRun + 1;
        if ({done, cycle_count} !== {1'b1, 5'd25}) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL run_halt: got done=%b cnt=%0d, required done=1 cnt=25", done, cycle_count);
        end
        holt = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        testsRun = testsRun + 1;
        if ({done, cycle_count, in_ready} !== {1'b1, 5'd25, 1'b0}) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL run_frozen: got done=%b cnt=%0d rdy=%b, required done=1 cnt=25 rdy=0",
                     done, cycle_count, in_ready);
        end
        testsRun = testsRun + 1;
        if (expQ.size() !== 0) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL run_pending: got %0d writes missing, required 0", expQ.size());
        end
    endtask

    task automatic test_saturation();
        pulseReset();
        holt = 1'b0;
        imgWords.delete();
        imgWords.push_back(16'hC0DE);
        loadImage(1, 0);
        waitCoreRelease();
        repeat (40) @(posedge CLK);
        #1;
        testsRun = testsRun + 1;
        if ({done, cycle_count} !== {1'b0, {CNT_W{1'b1}}}) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL saturation: got done=%b cnt=%0d, required done=0 cnt=31", done, cycle_count);
        end
        holt = 1'b1;
        @(posedge CLK);
        #1;
        holt = 1'b0;
    endtask

    task automatic test_overflow(input int gapMax);
        pulseReset();
        holt = 1'b0;
        imgWords.delete();
        for (int i = 1; i <= 5; i++) imgWords.push_back(16'(i * 16'h1111));
        loadImage(5, gapMax);
        repeat (3) @(posedge CLK);
        #1;
        testsRun = testsRun + 1;
        if (weCount !== 4) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL overflow_write_count: got %0d strobes, required 4", weCount);
        end
        testsRun = testsRun + 1;
        if (expQ.size() !== 0) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL overflow_pending: got %0d writes missing, required 0", expQ.size());
        end
        testsRun = testsRun + 1;
        if ({ovf, core_rst_n, in_ready} !== 3'b110) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL overflow_flags: got ovf=%b crst=%b rdy=%b, required 1 1 0", ovf, core_rst_n, in_ready);
        end
        testsRun = testsRun + 1;
        if (riseCyc !== lastAcceptCyc + 1) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL overflow_release_time: got cycle %0d, required %0d", riseCyc, lastAcceptCyc + 1);
        end
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pulseReset();
        holt    = 1'b0;
        chkFlip = 8'h00;
        imgWords.delete();
        imgWords.push_back(16'h1234);
        loadImage(1, 0);
        repeat (3) @(posedge CLK);
        #1;
        testsRun = testsRun + 1;
        if ({err, core_rst_n, in_ready} !== 3'b010 || riseCyc !== lastAcceptCyc + 1) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL checksum_good: got err=%b crst=%b rdy=%b rise=%0d, required 0 1 0 rise=%0d",
                     err, core_rst_n, in_ready, riseCyc, lastAcceptCyc + 1);
        end
        pulseReset();
        chkFlip = 8'h01;
        imgWords.delete();
        imgWords.push_back(16'h1234);
        loadImage(1, 0);
        repeat (5) @(posedge CLK);
        #1;
        chkFlip = 8'h00;
        testsRun = testsRun + 1;
        if ({err, core_rst_n, in_ready, done} !== 4'b1000) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL checksum_bad: got err=%b crst=%b rdy=%b done=%b, required 1 0 0 0",
                     err, core_rst_n, in_ready, done);
        end
        testsRun = testsRun + 1;
        if (expQ.size() !== 0) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL checksum_pending: got %0d writes missing, required 0", expQ.size());
        end
    endtask
`endif

    task automatic test_reset_mid_load();
        pulseReset();
        holt = 1'b0;
        applyStimulus(8'h00, 0);
        applyStimulus(8'h03, 0);
        applyStimulus(8'h12, 0);
        in_valid = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        testsRun = testsRun + 1;
        if ({in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, cycle_count, done, ovf, err}
            !== {1'b1, 1'b0, {ADDR_W{1'b0}}, 16'h0000, 1'b0, {CNT_W{1'b0}}, 3'b000}) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL midload_reset_values: got rdy=%b we=%b addr=%0d wdata=%h crst=%b cnt=%0d done=%b ovf=%b err=%b, required rdy=1 rest 0",
                     in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, cycle_count, done, ovf, err);
        end
        clearTracking();
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        test_basic_load(0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_load(0, 1'b1);
        test_empty_image();
        test_run_count();
        test_saturation();
        test_overflow(0);
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_load();
        test_basic_load(3, 1'b1);
        test_overflow(3);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
